// File: rtl/ksa_pkg.sv
// Shared encodings for the KSA32 sharing arbiter.
// Op codes, lock FSM states and the requester-ID width helper.
package ksa_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_share_arbiter_rr.sv
// Combinational round-robin picker: first set bit
// scanning ptr, ptr+1, ... modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/ksa32.sv
// 32-bit Kogge-Stone adder with carry-in and carry-out.
// Five prefix levels; carry-in is folded into bit 0 generate.
module ksa32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  function automatic logic [31:0] ks_g(
    input logic [31:0] g,
    input logic [31:0] p,
    input int          d
  );
    logic [31:0] gn;
    gn = g;
    for (int i = d; i < 32; i++)
      gn[i] = g[i] | (p[i] & g[i-d]);
    return gn;
  endfunction

  function automatic logic [31:0] ks_p(
    input logic [31:0] p,
    input int          d
  );
    logic [31:0] pn;
    pn = p;
    for (int i = d; i < 32; i++)
      pn[i] = p[i] & p[i-d];
    return pn;
  endfunction

  logic [31:0] p0, g0;
  logic [31:0] g1, p1, g2, p2;
  logic [31:0] g3, p3, g4, p4, g5;

  assign p0 = a_i ^ b_i;
  assign g0 = {(a_i[31:1] & b_i[31:1]),
               (a_i[0] & b_i[0]) | (p0[0] & cin_i)};

  assign g1 = ks_g(g0, p0, 1);
  assign p1 = ks_p(p0, 1);
  assign g2 = ks_g(g1, p1, 2);
  assign p2 = ks_p(p1, 2);
  assign g3 = ks_g(g2, p2, 4);
  assign p3 = ks_p(p2, 4);
  assign g4 = ks_g(g3, p3, 8);
  assign p4 = ks_p(p3, 8);
  assign g5 = ks_g(g4, p4, 16);

  assign sum_o  = p0 ^ {g5[30:0], cin_i};
  assign cout_o = g5[31];

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one KSA32 between NREQ requesters with round-robin
// grant, optional multi-beat lock and a lock timeout.
module add_share_arbiter
  import ksa_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [NREQ-1:0]        REQ_VALID,
  output logic [NREQ-1:0]        REQ_READY,
  input  logic [NREQ*32-1:0]     REQ_A,
  input  logic [NREQ*32-1:0]     REQ_B,
  input  logic [NREQ*2-1:0]      REQ_OP,
  input  logic [NREQ-1:0]        REQ_LOCK,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [31:0]            RSP_Y,
  output logic                   RSP_COUT,
  output logic [id_w(NREQ)-1:0]  RSP_ID,
  output logic                   LOCK_ABORT
);

  localparam int IDW = id_w(NREQ);

  function automatic logic [IDW-1:0] nxt(
    input logic [IDW-1:0] i
  );
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  state_e         state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] rr_ptr_q;
  logic           carry_q;
  logic [7:0]     idle_cnt_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_y_q;
  logic           rsp_cout_q;
  logic [IDW-1:0] rsp_id_q;
  logic           lock_abort_q;

  logic            locked, timeout, slot_free, accept;
  logic [NREQ-1:0] own_oh, cand, gnt_oh;
  logic [IDW-1:0]  g;
  logic            any;
  op_e             op;
  logic            lock_sel;
  logic [31:0]     a_sel, b_sel, sum;
  logic            cin, cout;

  assign locked    = (state_q == ST_LOCKED);
  assign timeout   = locked &&
                     (idle_cnt_q == 8'(LOCK_TIMEOUT));
  assign slot_free = !rsp_valid_q || RSP_READY;
  assign own_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign cand      = locked ? (REQ_VALID & own_oh)
                            : REQ_VALID;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (g),
    .any_o (any)
  );

  // A timeout cycle never accepts, even if the owner returns.
  assign accept    = RSTn && slot_free && any && !timeout;
  assign REQ_READY = accept ? gnt_oh : '0;

  assign op       = op_e'(REQ_OP[2*int'(g) +: 2]);
  assign lock_sel = REQ_LOCK[g];
  assign a_sel    = REQ_A[32*int'(g) +: 32];

  always_comb begin
    b_sel = REQ_B[32*int'(g) +: 32];
    cin   = 1'b0;
    unique case (1'b1)
      (op == OP_SUB): begin
        b_sel = ~REQ_B[32*int'(g) +: 32];
        cin   = 1'b1;
      end
      (op == OP_ADC): cin = carry_q;
      default: ;
    endcase
  end

  ksa32 u_ksa (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .cin_i  (cin),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      carry_q      <= 1'b0;
      idle_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= '0;
      lock_abort_q <= 1'b0;
    end else begin
      lock_abort_q <= 1'b0;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_y_q     <= sum;
        rsp_cout_q  <= cout;
        rsp_id_q    <= g;
        carry_q     <= cout;
      end else if (RSP_READY) begin
        rsp_valid_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rr_ptr_q <= nxt(g);
            if (lock_sel) begin
              state_q    <= ST_LOCKED;
              owner_q    <= g;
              idle_cnt_q <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (timeout) begin
            state_q      <= ST_IDLE;
            lock_abort_q <= 1'b1;
            idle_cnt_q   <= '0;
            rr_ptr_q     <= nxt(owner_q);
          end else if (accept) begin
            idle_cnt_q <= '0;
            if (!lock_sel) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= nxt(owner_q);
            end
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RSP_VALID  = rsp_valid_q;
  assign RSP_Y      = rsp_y_q;
  assign RSP_COUT   = rsp_cout_q;
  assign RSP_ID     = rsp_id_q;
  assign LOCK_ABORT = lock_abort_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter (NREQ=4, timeout 15).
// Expected values are hand-computed per step.
module tb_add_share_arbiter;

  localparam int NREQ = 4;

  logic                CLK;
  logic                RSTn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ*2-1:0]   req_op;
  logic [NREQ-1:0]     req_lock;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_y;
  logic                rsp_cout;
  logic [1:0]          rsp_id;
  logic                lock_abort;

  int n_cmp = 0;
  int n_err = 0;

  add_share_arbiter #(
    .NREQ         (NREQ),
    .LOCK_TIMEOUT (15)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_A      (req_a),
    .REQ_B      (req_b),
    .REQ_OP     (req_op),
    .REQ_LOCK   (req_lock),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_Y      (rsp_y),
    .RSP_COUT   (rsp_cout),
    .RSP_ID     (rsp_id),
    .LOCK_ABORT (lock_abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_lock  = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_req(input int i,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [1:0]  op,
                         input logic        lk);
    req_valid[i]      = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[2*i +: 2]  = op;
    req_lock[i]       = lk;
  endtask

  initial begin
    RSTn      = 1'b0;
    rsp_ready = 1'b1;
    clr();
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_y", rsp_y, 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_abort", 32'(lock_abort), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // round robin, rr_ptr starts at 0
    RSTn = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'd1, 32'(i), 2'b00, 1'b0);
    #1;
    chk("rr_pre_valid", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_y", rsp_y, 32'((c % 4) + 1));
      chk("rr_id", 32'(rsp_id), 32'(c % 4));
    end
    clr();
    tick();
    chk("rr_drain", 32'(rsp_valid), 32'd0);

    // SUB / borrow via req0 (rr_ptr=1)
    set_req(0, 32'd5, 32'd7, 2'b01, 1'b0);
    #1;
    chk("sub1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("sub1_y", rsp_y, 32'hFFFF_FFFE);
    chk("sub1_cout", 32'(rsp_cout), 32'd0);
    chk("sub1_id", 32'(rsp_id), 32'd0);
    set_req(0, 32'd7, 32'd5, 2'b01, 1'b0);
    #1;
    chk("sub2_ready", 32'(req_ready), 32'h1);
    tick();
    chk("sub2_y", rsp_y, 32'd2);
    chk("sub2_cout", 32'(rsp_cout), 32'd1);
    clr();
    tick();

    // 64-bit chain: req1 locks, req0 waits (rr_ptr=1)
    set_req(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1);
    set_req(0, 32'h100, 32'h23, 2'b00, 1'b0);
    #1;
    chk("ch_lo_ready", 32'(req_ready), 32'h2);
    tick();
    chk("ch_lo_y", rsp_y, 32'd0);
    chk("ch_lo_cout", 32'(rsp_cout), 32'd1);
    chk("ch_lo_id", 32'(rsp_id), 32'd1);
    set_req(1, 32'd0, 32'd0, 2'b10, 1'b0);
    #1;
    chk("ch_hi_ready", 32'(req_ready), 32'h2);
    tick();
    chk("ch_hi_y", rsp_y, 32'd1);
    chk("ch_hi_cout", 32'(rsp_cout), 32'd0);
    chk("ch_hi_id", 32'(rsp_id), 32'd1);
    req_valid[1] = 1'b0;
    #1;
    chk("ch_r0_ready", 32'(req_ready), 32'h1);
    tick();
    chk("ch_r0_y", rsp_y, 32'h123);
    chk("ch_r0_id", 32'(rsp_id), 32'd0);
    clr();
    tick();

    // backpressure (rr_ptr=1)
    set_req(2, 32'd10, 32'd20, 2'b00, 1'b0);
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h4);
    tick();
    chk("bp_y0", rsp_y, 32'd30);
    rsp_ready = 1'b0;
    set_req(2, 32'd40, 32'd2, 2'b00, 1'b0);
    set_req(3, 32'd3, 32'd4, 2'b00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_y", rsp_y, 32'd30);
      chk("bp_hold_id", 32'(rsp_id), 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'h8);
    tick();
    chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rel_y", rsp_y, 32'd7);
    chk("bp_rel_id", 32'(rsp_id), 32'd3);
    clr();
    tick();
    chk("bp_drain", 32'(rsp_valid), 32'd0);

    // lock timeout (rr_ptr=0)
    set_req(2, 32'd1, 32'd1, 2'b00, 1'b1);
    #1;
    chk("to_lock_ready", 32'(req_ready), 32'h4);
    tick();
    chk("to_lock_y", rsp_y, 32'd2);
    clr();
    set_req(3, 32'h55, 32'd0, 2'b00, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      #1;
      chk("to_wait_abort", 32'(lock_abort), 32'd0);
      chk("to_wait_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("to_abort", 32'(lock_abort), 32'd1);
    chk("to_r3_ready", 32'(req_ready), 32'h8);
    tick();
    chk("to_abort_end", 32'(lock_abort), 32'd0);
    chk("to_r3_y", rsp_y, 32'h55);
    chk("to_r3_id", 32'(rsp_id), 32'd3);
    clr();
    tick();

    // async reset with a held response (rr_ptr=0)
    set_req(1, 32'hFFFF_FFFF, 32'd3, 2'b00, 1'b0);
    #1;
    tick();
    chk("mr_y", rsp_y, 32'd2);
    chk("mr_cout", 32'(rsp_cout), 32'd1);
    chk("mr_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    chk("mr_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rst_y", rsp_y, 32'd0);
    chk("mr_rst_cout", 32'(rsp_cout), 32'd0);
    chk("mr_rst_id", 32'(rsp_id), 32'd0);
    chk("mr_rst_ready", 32'(req_ready), 32'd0);
    tick();
    RSTn      = 1'b1;
    rsp_ready = 1'b1;
    clr();
    set_req(1, 32'd5, 32'd0, 2'b10, 1'b0);
    #1;
    chk("mr_post_valid", 32'(rsp_valid), 32'd0);
    chk("mr_post_ready", 32'(req_ready), 32'h2);
    tick();
    chk("mr_lat_valid", 32'(rsp_valid), 32'd1);
    chk("mr_adc_y", rsp_y, 32'd5);
    chk("mr_adc_cout", 32'(rsp_cout), 32'd0);
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
